// File: rtl/ofifo_col_pkg.sv
// ofifo_col_pkg: shared constants and helpers for the output FIFO column block.
//   COL / PSUM_BW / OFIFO_DEPTH : default lane count, word width, lane depth
//   clog2()                     : pointer width from depth
//   lane_lo()                   : lane i occupies bus bits [lane_lo(i)+bw-1 : lane_lo(i)]
package ofifo_col_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) < v) r = k + 1;
    return r;
  endfunction

  // Lane 0 sits in the least significant slice of a packed row.
  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane: single-width synchronous FIFO for one array column.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push, din  : write request and data; dropped when full
//   pop        : read request; ignored when empty
//   dout       : current head word (combinational read of the head slot)
//   full, empty, count : occupancy status, count in 0..depth
module ofifo_lane
  import ofifo_col_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH,
  parameter int ptr_bw  = clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [ptr_bw:0]    count
);

  logic [psum_bw-1:0] mem [depth];
  logic [ptr_bw-1:0]  wptr, rptr;
  logic               push_ok, pop_ok;

  assign full    = (count == (ptr_bw+1)'(depth));
  assign empty   = (count == '0);
  // Full check uses the pre-edge count, so a full lane drops the write
  // even if a pop frees a slot at the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage is never cleared; only gated writes land.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ptr_bw'(1);
      if (pop_ok)  rptr <= rptr + ptr_bw'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ptr_bw+1)'(1);
        2'b01:   count <= count - (ptr_bw+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofifo_col.sv
// ofifo_col: per-column capture FIFOs that re-align skewed array outputs and
// release one full row per accepted pop.
//   clk, reset : clock, synchronous active-high reset
//   in, wr     : per-lane psum words and write enables (lane i = in[lane_lo(i)+:psum_bw])
//   rd         : row pop request, accepted only when o_valid
//   out        : registered popped row, holds between pops
//   o_full     : some lane full;  o_ready : every lane can take a push
//   o_valid    : every lane non-empty
//   o_err      : only when OFIFO_ERR_FLAG_EN is defined; sticky
//                [0] write to a full lane, [1] rd while o_valid=0
module ofifo_col
  import ofifo_col_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH,
  parameter int ptr_bw  = clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid
`ifdef OFIFO_ERR_FLAG_EN
  ,
  output logic [1:0]             o_err
`endif
);

  logic [col-1:0]              full_v, empty_v, can_push;
  logic [col-1:0][ptr_bw:0]    cnt;
  logic [col*psum_bw-1:0]      head_row;
  logic                        pop;

  // Every lane advances together, so a row is only popped when all have data.
  assign pop = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth),
      .ptr_bw  (ptr_bw)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (wr[i]),
      .pop   (pop),
      .din   (in[lane_lo(i, psum_bw) +: psum_bw]),
      .dout  (head_row[lane_lo(i, psum_bw) +: psum_bw]),
      .full  (full_v[i]),
      .empty (empty_v[i]),
      .count (cnt[i])
    );
    assign can_push[i] = (cnt[i] != (ptr_bw+1)'(depth));
  end

  assign o_valid = &(~empty_v);
  assign o_full  = |full_v;
  assign o_ready = &can_push;

  always_ff @(posedge clk) begin
    if (reset)    out <= '0;
    else if (pop) out <= head_row;
  end

`ifdef OFIFO_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= 2'b00;
    end else begin
      if (|(wr & full_v))   o_err[0] <= 1'b1;
      if (rd & ~o_valid)    o_err[1] <= 1'b1;
    end
  end
`endif

endmodule
